// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if
//   Groups the decode/execute observation signals and the buffer control
//   outputs of the pipeline hazard controller.
//   master : pipeline side; drives the instruction/event inputs and observes the controls.
//   slave  : hazard controller; consumes the inputs and drives the controls.
//   Signals:
//     id_inst[15:0]      instruction in ID (op[15:12] rd[11:8] rs[7:4] rt[3:0])
//     ex_inst[15:0]      instruction held in ID/EX, same layout
//     ex_mem_read        EX instruction is a load
//     branch_taken       branch resolved taken in EX
//     mul_start          first EX cycle of a multi-cycle op
//     halt_req           halt decoded in ID
//     resume             external restart request
//     pc_en              PC may update
//     if_id_hold/flush   IF/ID buffer keep / load NOP
//     id_ex_hold/flush   ID/EX buffer keep / load bubble
//     halted             pipeline frozen by halt
//     ctrl_state[1:0]    00 RUN, 01 STALL, 10 HALT
//     stall_cycles[15:0] stall cycle counter (zero unless PIPE_HAZARD_PERF_EN)
interface pipe_hazard_ctrl_if;
    logic [15:0] id_inst;
    logic [15:0] ex_inst;
    logic        ex_mem_read;
    logic        branch_taken;
    logic        mul_start;
    logic        halt_req;
    logic        resume;
    logic        pc_en;
    logic        if_id_hold;
    logic        if_id_flush;
    logic        id_ex_hold;
    logic        id_ex_flush;
    logic        halted;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles;

    modport master (
        output id_inst, ex_inst, ex_mem_read, branch_taken, mul_start, halt_req, resume,
        input  pc_en, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, halted,
               ctrl_state, stall_cycles
    );

    modport slave (
        input  id_inst, ex_inst, ex_mem_read, branch_taken, mul_start, halt_req, resume,
        output pc_en, if_id_hold, if_id_flush, id_ex_hold, id_ex_flush, halted,
               ctrl_state, stall_cycles
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline hazard controller: branch flush, multi-cycle EX freeze,
//   load-use bubble insertion and halt/resume.
//   Ports:
//     clk  rising-edge clock
//     rst  asynchronous active-high reset, released synchronously by the system
//     bus  pipe_hazard_ctrl_if.slave (instruction/event inputs, buffer controls)
//   Parameter:
//     MUL_CYCLES  total EX occupancy of a multi-cycle op, 2..16 (default 4)
//   Optional feature:
//     PIPE_HAZARD_PERF_EN  when defined, stall_cycles counts clocks with pc_en=0
//                          (saturating); otherwise it is tied to zero.
module pipe_hazard_ctrl #(
    parameter int unsigned MUL_CYCLES = 4
) (
    input logic              clk,
    input logic              rst,
    pipe_hazard_ctrl_if.slave bus
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_STALL = 2'b01;
    localparam logic [1:0] ST_HALT  = 2'b10;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 2);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [3:0] id_rs, id_rt, ex_rd;
    logic       load_use;

    logic pc_en_c, if_id_hold_c, if_id_flush_c, id_ex_hold_c, id_ex_flush_c, halted_c;

    // Opcode and source fields of the EX instruction do not affect hazards.
    logic unused_fields;
    assign unused_fields = ^{bus.id_inst[15:8], bus.ex_inst[15:12], bus.ex_inst[7:0]};

    assign id_rs = bus.id_inst[7:4];
    assign id_rt = bus.id_inst[3:0];
    assign ex_rd = bus.ex_inst[11:8];

    assign load_use = bus.ex_mem_read && (ex_rd != 4'd0) &&
                      ((ex_rd == id_rs) || (ex_rd == id_rt));

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_en_c       = 1'b1;
        if_id_hold_c  = 1'b0;
        if_id_flush_c = 1'b0;
        id_ex_hold_c  = 1'b0;
        id_ex_flush_c = 1'b0;
        halted_c      = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (bus.branch_taken) begin
                    if_id_flush_c = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (bus.mul_start) begin
                    pc_en_c      = 1'b0;
                    if_id_hold_c = 1'b1;
                    id_ex_hold_c = 1'b1;
                    cnt_d        = MUL_LOAD;
                    // With MUL_CYCLES=2 the RUN cycle alone is the whole freeze.
                    state_d      = (MUL_CYCLES > 2) ? ST_STALL : ST_RUN;
                end else if (load_use) begin
                    pc_en_c       = 1'b0;
                    if_id_hold_c  = 1'b1;
                    id_ex_flush_c = 1'b1;
                end else if (bus.halt_req) begin
                    pc_en_c       = 1'b0;
                    if_id_hold_c  = 1'b1;
                    id_ex_flush_c = 1'b1;
                    state_d       = ST_HALT;
                end
            end
            ST_STALL: begin
                pc_en_c      = 1'b0;
                if_id_hold_c = 1'b1;
                id_ex_hold_c = 1'b1;
                // Counter was loaded with MUL_CYCLES-2 in the RUN cycle; leaving
                // when it reaches 1 gives MUL_CYCLES-2 STALL cycles, i.e. a total
                // freeze of MUL_CYCLES-1 including that RUN cycle.
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HALT: begin
                pc_en_c      = 1'b0;
                if_id_hold_c = 1'b1;
                id_ex_hold_c = 1'b1;
                halted_c     = 1'b1;
                if (bus.resume) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = 4'd0;
            end
        endcase

        // Outputs are forced to their idle values for the whole reset pulse,
        // independent of whatever the inputs are doing.
        if (rst) begin
            pc_en_c       = 1'b1;
            if_id_hold_c  = 1'b0;
            if_id_flush_c = 1'b0;
            id_ex_hold_c  = 1'b0;
            id_ex_flush_c = 1'b0;
            halted_c      = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc_en       = pc_en_c;
    assign bus.if_id_hold  = if_id_hold_c;
    assign bus.if_id_flush = if_id_flush_c;
    assign bus.id_ex_hold  = id_ex_hold_c;
    assign bus.id_ex_flush = id_ex_flush_c;
    assign bus.halted      = halted_c;
    assign bus.ctrl_state  = state_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (!pc_en_c && (perf_q != 16'hFFFF)) begin
            perf_d = perf_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_q <= 16'h0000;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign bus.stall_cycles = perf_q;
`else
    assign bus.stall_cycles = 16'h0000;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Directed self-checking bench for pipe_hazard_ctrl (MUL_CYCLES=4).
//   Control outputs are packed as {pc_en, if_id_hold, if_id_flush,
//   id_ex_hold, id_ex_flush, halted, ctrl_state[1:0]}.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl #(.MUL_CYCLES(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected packed control words
    localparam logic [7:0] C_IDLE  = 8'h80;
    localparam logic [7:0] C_BR    = 8'hA8;
    localparam logic [7:0] C_MUL   = 8'h50;
    localparam logic [7:0] C_STALL = 8'h51;
    localparam logic [7:0] C_BUB   = 8'h48;
    localparam logic [7:0] C_HALT  = 8'h56;

`ifdef PIPE_HAZARD_PERF_EN
    localparam logic [15:0] HALT_STALLS = 16'd7;
`else
    localparam logic [15:0] HALT_STALLS = 16'd0;
`endif

    function automatic logic [7:0] ctl();
        return {bus.pc_en, bus.if_id_hold, bus.if_id_flush, bus.id_ex_hold,
                bus.id_ex_flush, bus.halted, bus.ctrl_state};
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.id_inst      = 16'h0000;
        bus.ex_inst      = 16'h0000;
        bus.ex_mem_read  = 1'b0;
        bus.branch_taken = 1'b0;
        bus.mul_start    = 1'b0;
        bus.halt_req     = 1'b0;
        bus.resume       = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        idle_inputs();
        // Events present during reset must not leak through
        bus.branch_taken = 1'b1;
        bus.mul_start    = 1'b1;
        #2;
        chk("reset_ctl", {8'h00, ctl()}, {8'h00, C_IDLE});
        chk("reset_stall_cycles", bus.stall_cycles, 16'h0000);
        tick();
        tick();
        idle_inputs();
        rst = 1'b0;
        #2;
        chk("run_idle", {8'h00, ctl()}, {8'h00, C_IDLE});

        // resume outside HALT is ignored
        bus.resume = 1'b1;
        #1;
        chk("resume_in_run", {8'h00, ctl()}, {8'h00, C_IDLE});
        tick();
        bus.resume = 1'b0;
        #1;
        chk("resume_in_run_next", {8'h00, ctl()}, {8'h00, C_IDLE});

        // Halt, 5 frozen cycles, resume in the sixth
        bus.halt_req = 1'b1;
        #1;
        chk("halt_req_cycle", {8'h00, ctl()}, {8'h00, C_BUB});
        tick();
        bus.halt_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            // Events are ignored in HALT
            bus.branch_taken = (i == 2);
            bus.mul_start    = (i == 3);
            #1;
            chk("halt_hold", {8'h00, ctl()}, {8'h00, C_HALT});
            tick();
        end
        bus.branch_taken = 1'b0;
        bus.mul_start    = 1'b0;
        bus.resume       = 1'b1;
        #1;
        chk("halt_resume_cycle", {8'h00, ctl()}, {8'h00, C_HALT});
        tick();
        bus.resume = 1'b0;
        #1;
        chk("after_resume", {8'h00, ctl()}, {8'h00, C_IDLE});
        chk("halt_stall_cycles", bus.stall_cycles, HALT_STALLS);

        // Load-use on rs: one bubble then run
        bus.ex_inst     = 16'h4300;
        bus.ex_mem_read = 1'b1;
        bus.id_inst     = 16'h1530;
        #1;
        chk("load_use_rs", {8'h00, ctl()}, {8'h00, C_BUB});
        tick();
        bus.ex_inst     = 16'h0000;
        bus.ex_mem_read = 1'b0;
        #1;
        chk("load_use_after", {8'h00, ctl()}, {8'h00, C_IDLE});

        // Load-use on rt
        bus.ex_inst     = 16'h4300;
        bus.ex_mem_read = 1'b1;
        bus.id_inst     = 16'h1503;
        #1;
        chk("load_use_rt", {8'h00, ctl()}, {8'h00, C_BUB});

        // Destination r0 never hazards
        bus.ex_inst = 16'h4000;
        bus.id_inst = 16'h1000;
        #1;
        chk("load_rd_zero", {8'h00, ctl()}, {8'h00, C_IDLE});

        // Match without a load is not a hazard
        bus.ex_inst     = 16'h4300;
        bus.id_inst     = 16'h1530;
        bus.ex_mem_read = 1'b0;
        #1;
        chk("no_load_no_hazard", {8'h00, ctl()}, {8'h00, C_IDLE});

        // Branch beats halt and load-use
        bus.ex_mem_read  = 1'b1;
        bus.branch_taken = 1'b1;
        bus.halt_req     = 1'b1;
        #1;
        chk("branch_priority", {8'h00, ctl()}, {8'h00, C_BR});
        tick();
        idle_inputs();
        #1;
        chk("after_branch", {8'h00, ctl()}, {8'h00, C_IDLE});

        // Multi-cycle op beats load-use: 3 frozen cycles, 2 in STALL
        bus.ex_inst     = 16'h4300;
        bus.ex_mem_read = 1'b1;
        bus.id_inst     = 16'h1530;
        bus.mul_start   = 1'b1;
        #1;
        chk("mul_run_cycle", {8'h00, ctl()}, {8'h00, C_MUL});
        tick();
        bus.mul_start    = 1'b0;
        bus.branch_taken = 1'b1;
        bus.halt_req     = 1'b1;
        #1;
        chk("mul_stall_1", {8'h00, ctl()}, {8'h00, C_STALL});
        tick();
        bus.branch_taken = 1'b0;
        bus.halt_req     = 1'b0;
        bus.mul_start    = 1'b1;
        #1;
        chk("mul_stall_2", {8'h00, ctl()}, {8'h00, C_STALL});
        tick();
        idle_inputs();
        #1;
        chk("mul_done", {8'h00, ctl()}, {8'h00, C_IDLE});

        // Reset in the middle of STALL aborts immediately
        bus.mul_start = 1'b1;
        #1;
        chk("mul2_run_cycle", {8'h00, ctl()}, {8'h00, C_MUL});
        tick();
        bus.mul_start = 1'b0;
        #1;
        chk("mul2_stall", {8'h00, ctl()}, {8'h00, C_STALL});
        rst = 1'b1;
        #1;
        chk("rst_mid_stall_ctl", {8'h00, ctl()}, {8'h00, C_IDLE});
        chk("rst_mid_stall_cnt", bus.stall_cycles, 16'h0000);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ctl", {8'h00, ctl()}, {8'h00, C_IDLE});
        tick();
        #1;
        chk("post_rst_ctl_next", {8'h00, ctl()}, {8'h00, C_IDLE});

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
